bs_regfile: RTL and testbench

Parametrised bit-serial general-purpose register file for the bit-serial datapath. Holds NREG registers of WIDTH bits and runs one WIDTH-cycle serial transfer per command: streams a source register out LSB-first while shifting a serial result into a destination register. A small sequencer FSM with a bit counter replaces the external per-bit shift control of the earlier two-register, 8-bit GPR. A parallel read port serves debug and display.

---
 rtl/bs_pkg.sv | 9 +
 rtl/bs_shift_lane.sv | 36 +++
 rtl/bs_regfile.sv | 108 ++++++++++
 tb/tb_bs_regfile.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types for the bit-serial register file: sequencer state encoding.
package bs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bs_state_e;

endpackage

// File: rtl/bs_shift_lane.sv
// One bit-serial register lane: holds, shifts a serial bit in at the MSB, or rotates right.
module bs_shift_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_i,
    input  logic             rotate_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Shift-in wins over rotate so an in-place read-modify-write fills with new bits.
    always_comb begin
        q_d = q_q;
        if (shift_i) begin
            q_d = {sin_i, q_q[WIDTH-1:1]};
        end else if (rotate_i) begin
            q_d = {q_q[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bs_regfile.sv
// Bit-serial register file: NREG lanes, a start/busy sequencer with a bit counter,
// a serial source stream out and a combinational parallel read port.
module bs_regfile
    import bs_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [AW-1:0]    i_rd_addr,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic             i_wr_en,
    input  logic             i_data_in,
    input  logic             i_data_sign,
    input  logic             i_con_sign,
    output logic             o_busy,
    output logic             o_data_out,
    output logic             o_last,
    input  logic [AW-1:0]    i_par_addr,
    output logic [WIDTH-1:0] o_par_out,
    output bs_state_e        o_state
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    bs_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic             wen_q, wen_d;
    logic             busy;
    logic             bit_in;
    logic [WIDTH-1:0] lane_q [NREG];

    // Command handshake: i_start is a one-cycle request taken only in IDLE; there is
    // no ready, a request seen while BUSY is dropped, and o_busy marks the WIDTH cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wen_d   = wen_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    rd_d    = i_rd_addr;
                    wr_d    = i_wr_addr;
                    wen_d   = i_wr_en;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wen_q   <= wen_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign bit_in = i_con_sign ? i_data_sign : i_data_in;

    for (genvar g = 0; g < NREG; g++) begin : g_lane
        logic sel_wr;
        logic sel_rd;
        assign sel_wr = busy && wen_q && (wr_q == AW'(g));
        assign sel_rd = busy && (rd_q == AW'(g));
        bs_shift_lane #(.WIDTH(WIDTH)) u_lane (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .shift_i (sel_wr),
            .rotate_i(sel_rd && !sel_wr),
            .sin_i   (bit_in),
            .q_o     (lane_q[g])
        );
    end

    assign o_busy     = busy;
    assign o_last     = busy && (cnt_q == LAST);
    assign o_data_out = busy && lane_q[rd_q][0];
    assign o_par_out  = lane_q[i_par_addr];
    assign o_state    = state_q;

endmodule

// File: tb/tb_bs_regfile.sv
// Directed bench for bs_regfile: transfer-level model checked every cycle, plus literal checks.
module tb_bs_regfile;
    import bs_pkg::*;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [AW-1:0] i_wr_addr = '0;
    logic          i_wr_en = 1'b0;
    logic          i_data_in = 1'b0;
    logic          i_data_sign = 1'b0;
    logic          i_con_sign = 1'b0;
    logic          o_busy;
    logic          o_data_out;
    logic          o_last;
    logic [AW-1:0] i_par_addr = '0;
    logic [W-1:0]  o_par_out;
    bs_state_e     o_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    logic [W-1:0] exp_q[$];

    bs_regfile #(.WIDTH(W), .NREG(N)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_rd_addr  (i_rd_addr),
        .i_wr_addr  (i_wr_addr),
        .i_wr_en    (i_wr_en),
        .i_data_in  (i_data_in),
        .i_data_sign(i_data_sign),
        .i_con_sign (i_con_sign),
        .o_busy     (o_busy),
        .o_data_out (o_data_out),
        .o_last     (o_last),
        .i_par_addr (i_par_addr),
        .o_par_out  (o_par_out),
        .o_state    (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Transfer-level model: snapshot source/destination at accept, collect input bits,
    // commit the destination after WIDTH bits; partial views are derived arithmetically.
    logic [W-1:0]  m_regs [N];
    bit            m_busy = 1'b0;
    int            m_k = 0;
    logic [AW-1:0] m_rd, m_wr;
    bit            m_wen;
    logic [W-1:0]  m_S, m_D, m_bits;

    always @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_busy = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            if (i_start) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_rd   = i_rd_addr;
                m_wr   = i_wr_addr;
                m_wen  = i_wr_en;
                m_S    = m_regs[i_rd_addr];
                m_D    = m_regs[i_wr_addr];
                m_bits = '0;
            end
        end else begin
            m_bits[m_k] = i_con_sign ? i_data_sign : i_data_in;
            if (m_k == W - 1) begin
                if (m_wen) m_regs[m_wr] = m_bits;
                m_busy = 1'b0;
                m_k    = 0;
            end else begin
                m_k++;
            end
        end
    end

    function automatic logic [W-1:0] view(input logic [AW-1:0] a);
        if (!m_busy) return m_regs[a];
        if (m_wen && a == m_wr) return (m_D >> m_k) | (m_bits << (W - m_k));
        if (a == m_rd) return (m_S >> m_k) | (m_S << (W - m_k));
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("busy", 32'(o_busy), 32'(m_busy));
            chk("last", 32'(o_last), 32'(m_busy && m_k == W - 1));
            chk("data_out", 32'(o_data_out), 32'(m_busy ? m_S[m_k] : 1'b0));
            chk("par_out", 32'(o_par_out), 32'(view(i_par_addr)));
        end
    end

    task automatic peek(input int a, input logic [W-1:0] exp, input string name);
        i_par_addr = AW'(a);
        #1;
        chk(name, 32'(o_par_out), 32'(exp));
    endtask

    // Caller is at posedge+2 of an idle cycle; returns at posedge+2 of the idle cycle after.
    task automatic xfer(input int rd, input int wr, input bit wen,
                        input logic [W-1:0] din, input logic [W-1:0] con,
                        input logic [W-1:0] sgn, input bit fb, input int pulse_k,
                        output logic [W-1:0] stream, output int nbusy, output int nlast);
        stream = '0;
        nbusy  = 0;
        nlast  = 0;
        i_start   = 1'b1;
        i_rd_addr = AW'(rd);
        i_wr_addr = AW'(wr);
        i_wr_en   = wen;
        for (int k = 0; k < W; k++) begin
            @(posedge i_clk);
            #2;
            i_start   = (k == pulse_k);
            i_rd_addr = AW'(~rd);
            i_wr_addr = AW'(~wr);
            i_wr_en   = ~wen;
            i_par_addr = AW'(k);
            stream[k] = o_data_out;
            if (o_busy) nbusy++;
            if (o_last) nlast++;
            i_data_in   = fb ? o_data_out : din[k];
            i_con_sign  = con[k];
            i_data_sign = sgn[k];
        end
        @(posedge i_clk);
        #2;
        i_start     = 1'b0;
        i_data_in   = 1'b0;
        i_con_sign  = 1'b0;
        i_data_sign = 1'b0;
        if (o_busy) nbusy++;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 16;
        while (o_busy && budget > 0) begin
            @(posedge i_clk);
            #2;
            budget--;
        end
        chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] s;
        int nb, nl;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst  = 1'b0;
        cmp_en = 1'b1;

        for (int a = 0; a < N; a++) peek(a, 8'h00, "reset_reg");
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_last", 32'(o_last), 32'd0);

        // Write 0xA5 into r2 from the serial input.
        xfer(0, 2, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, -1, s, nb, nl);
        chk("wr_stream", 32'(s), 32'h00);
        chk("wr_busy_cycles", 32'(nb), 32'd8);
        chk("wr_last_cycles", 32'(nl), 32'd1);
        peek(2, 8'hA5, "wr_r2");

        // Copy r2 -> r1 by feeding the stream back.
        exp_q.push_back(8'hA5);
        xfer(2, 1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, -1, s, nb, nl);
        chk("copy_stream", 32'(s), 32'(exp_q.pop_front()));
        peek(1, 8'hA5, "copy_r1");
        peek(2, 8'hA5, "copy_r2_kept");

        // Sign fill: low nibble from data, upper nibble from sign.
        xfer(0, 3, 1'b1, 8'h03, 8'hF0, 8'hFF, 1'b0, -1, s, nb, nl);
        peek(3, 8'hF3, "sign_r3");

        // In-place RMW on r2 with a start pulse mid-transfer, back-to-back after the last one.
        exp_q.push_back(8'hA5);
        xfer(2, 2, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3, s, nb, nl);
        chk("rmw_stream", 32'(s), 32'(exp_q.pop_front()));
        chk("rmw_busy_cycles", 32'(nb), 32'd8);
        peek(2, 8'h00, "rmw_r2");
        peek(1, 8'hA5, "rmw_r1_kept");
        wait_idle();

        // Reset in the middle of a write to r1.
        i_start   = 1'b1;
        i_rd_addr = 2'd3;
        i_wr_addr = 2'd1;
        i_wr_en   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk);
            #2;
            i_start   = 1'b0;
            i_data_in = 1'b1;
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        i_rst     = 1'b0;
        i_data_in = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        for (int a = 0; a < N; a++) peek(a, 8'h00, "abort_reg");

        // Fresh write, then a back-to-back read-only transfer of the same register.
        xfer(3, 0, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b0, -1, s, nb, nl);
        peek(0, 8'h3C, "fresh_r0");
        exp_q.push_back(8'h3C);
        xfer(0, 3, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, -1, s, nb, nl);
        chk("ro_stream", 32'(s), 32'(exp_q.pop_front()));
        peek(0, 8'h3C, "ro_r0_kept");
        peek(3, 8'h00, "ro_r3_untouched");
        wait_idle();

        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
